// File: rtl/axis_pkg.sv
// Shared AXI-stream definitions for the byte-to-word packing path.
package axis_pkg;

  localparam int BYTE_W    = 8;
  // Widest word the keep helper has to describe (OUT_BYTES is at most 8).
  localparam int MAX_LANES = 8;

  // Returns a mask with the n low bits set (n = 0..MAX_LANES).
  function automatic logic [MAX_LANES-1:0] keep_mask(input logic [3:0] n);
    logic [MAX_LANES-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      mask[i] = (4'(i) < n);
    end
    return mask;
  endfunction

endpackage

// File: rtl/axis_byte_to_word_packer.sv
// Packs an 8-bit AXI byte stream into OUT_BYTES-wide little-endian words
// with a per-lane keep mask; in_last closes the current (possibly partial)
// word and marks it with out_last. Counts delivered packets.
module axis_byte_to_word_packer
  import axis_pkg::*;
#(
  parameter int OUT_BYTES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BYTE_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  output logic [BYTE_W*OUT_BYTES-1:0] out_data,
  output logic [OUT_BYTES-1:0]        out_keep,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [CNT_W-1:0]            pkt_count
);

  localparam int IDX_W  = $clog2(OUT_BYTES);
  localparam int WORD_W = BYTE_W * OUT_BYTES;

  // Accumulator state. Lanes are always filled from 0 upward, so the keep
  // mask of the word under construction is fully implied by the lane index.
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0]    acc_q, acc_d;

  // Output register state.
  logic [WORD_W-1:0]    out_data_q, out_data_d;
  logic [OUT_BYTES-1:0] out_keep_q, out_keep_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [CNT_W-1:0]     pkt_count_q, pkt_count_d;

  // Word as it looks with the incoming byte dropped into the current lane.
  logic [WORD_W-1:0]    acc_merged;
  logic [OUT_BYTES-1:0] keep_merged;
  logic                 byte_acc;
  logic                 word_done;
  logic                 out_xfer;

  // A byte can enter whenever the output slot is empty or being drained.
  assign in_ready  = ~out_valid_q | out_ready;
  assign byte_acc  = in_valid & in_ready;
  assign out_xfer  = out_valid_q & out_ready;
  assign word_done = byte_acc & ((idx_q == IDX_W'(OUT_BYTES - 1)) | in_last);

  // Lane steering: only the lane at idx_q takes the new byte.
  for (genvar gi = 0; gi < OUT_BYTES; gi++) begin : g_lane
    assign acc_merged[gi*BYTE_W +: BYTE_W] =
      (idx_q == IDX_W'(gi)) ? in_data : acc_q[gi*BYTE_W +: BYTE_W];
  end

  assign keep_merged = OUT_BYTES'(keep_mask(4'(idx_q) + 4'd1));

  // Accumulator next state: collect bytes, clear once a word completes.
  always_comb begin
    idx_d = idx_q;
    acc_d = acc_q;
    if (byte_acc) begin
      if (word_done) begin
        idx_d = '0;
        acc_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        acc_d = acc_merged;
      end
    end
  end

  // Accumulator register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

  // Output next state: a fresh word wins over draining, giving back-to-back
  // words without a bubble; a plain transfer only drops valid.
  always_comb begin
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    pkt_count_d = pkt_count_q;
    if (word_done) begin
      out_data_d  = acc_merged;
      out_keep_d  = keep_merged;
      out_last_d  = in_last;
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
    if (out_xfer && out_last_q) begin
      pkt_count_d = pkt_count_q + CNT_W'(1);
    end
  end

  // Output register and packet counter with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign pkt_count = pkt_count_q;

endmodule
